data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DATA_BUS_WIDTH, default 64, data bus width in bits (multiple of 8, 16..128).
REQ-002 SHALL have parameter ADDRESS_BUS_WIDTH, default 10, byte-address width.
REQ-003 SHALL have parameter NUM_DATA_BYTES, default 512, byte capacity (<= 2**ADDRESS_BUS_WIDTH).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port cs  input  1  chip select; requests are ignored when low.
REQ-007 SHALL have port req_valid  input  1  request present.
REQ-008 SHALL have port req_ready  output  1  controller can accept a request.
REQ-009 SHALL have port memRead  input  1  read request (wins over memWrite).
REQ-010 SHALL have port memWrite  input  1  write request.
REQ-011 SHALL have port address  input  ADDRESS_BUS_WIDTH  byte address.
REQ-012 SHALL have port size  input  2  access size: 0 byte, 1 half, 2 word, 3 double (lanes beyond DATA_BUS_WIDTH are illegal).
REQ-013 SHALL have port sign_ext  input  1  sign-extend narrow reads when high, zero-extend when low.
REQ-014 SHALL have port writeData  input  DATA_BUS_WIDTH  write data, little-endian, LSB-aligned.
REQ-015 SHALL have port readData  output  DATA_BUS_WIDTH  read data, registered.
REQ-016 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-017 SHALL have port resp_err  output  1  error flag, valid with resp_valid.

Function
REQ-018 SHALL accept a request on a rising edge where cs, req_valid, req_ready and (memRead or memWrite) are all high; address, size, sign_ext and writeData are captured then.
REQ-019 SHALL use FSM states IDLE, ACCESS, RESP; req_ready is high only in IDLE.
REQ-020 SHALL go IDLE->ACCESS on accept, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-021 SHALL give read latency 2 cycles from accept to resp_valid, with readData valid in the same cycle.
REQ-022 SHALL commit write bytes on the ACCESS edge and pulse resp_valid in RESP.
REQ-023 SHALL write exactly 2**size bytes; byte k of writeData goes to address+k, and other bytes are unchanged.
REQ-024 SHALL place read byte k from address+k in readData lane k and sign- or zero-extend above 2**size bytes.
REQ-025 SHALL flag an error when address is not a multiple of 2**size, when address+2**size exceeds NUM_DATA_BYTES, or when 2**size*8 exceeds DATA_BUS_WIDTH.
REQ-026 SHALL make an errored request leave memory unmodified, keep readData unchanged, and still produce resp_valid with resp_err=1 on the normal schedule.
REQ-027 SHALL hold readData until the next successful read completes; writes do not change it.
REQ-028 SHALL make a read that immediately follows a write to an overlapping address return the newly written bytes.
REQ-029 SHALL ignore req_valid while not in IDLE; the requester holds the request until req_ready.
REQ-030 SHALL ignore requests with cs low, or with memRead and memWrite both low, and stay in IDLE.
REQ-031 SHALL never drive outputs to Z.

Reset
REQ-032 SHALL, on reset_n low, immediately force FSM=IDLE, req_ready=1 (once released), readData=0, resp_valid=0, resp_err=0.
REQ-033 SHALL, on reset mid-operation, abort any pending access; a write not yet committed is dropped.
REQ-034 SHALL leave memory contents unaffected by reset; simulation init is all-zero except bytes 16=20, 32=22, 48=0.

Structure
REQ-035 SHALL keep the size encodings, FSM state encodings and default widths in the shared params package.
REQ-036 SHALL implement storage as sub-module byte_ram_array (byte-wide, per-byte write enable, synchronous read, no reset).

Verification
REQ-037 SHALL cover: reset, then read size=3 at address 16 -> resp_valid on cycle 2 with readData=64'd20 and resp_err=0.
REQ-038 SHALL cover: write size=1, address 32, data 16'hFF80, then read size=1 sign_ext=1 -> 64'hFFFF_FFFF_FFFF_FF80; the same read with sign_ext=0 -> 64'h0000_0000_0000_FF80.
REQ-039 SHALL cover: write size=2 at address 6 -> resp_err=1 and bytes 6..9 unchanged; read size=3 at address 508 -> resp_err=1.
REQ-040 SHALL cover: write size=0 at 100 = 8'hA5 followed back-to-back by read size=0 at 100 -> readData=64'hA5.
REQ-041 SHALL cover: reset_n asserted in ACCESS of a write to 200 -> no resp_valid, byte 200 unchanged, and req_ready=1 after release.
REQ-042 SHALL cover: req_valid held with cs=0 for 5 cycles -> no resp_valid and memory unchanged.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl_pkg
//  Purpose  : Shared definitions for the data memory controller: default
//             widths, access-size encodings, FSM state encodings, the
//             power-up memory image and a size-to-byte-count helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package data_mem_ctrl_pkg;

    // Default widths / capacity
    localparam int c_DEF_DATA_BUS_WIDTH    = 64;
    localparam int c_DEF_ADDRESS_BUS_WIDTH = 10;
    localparam int c_DEF_NUM_DATA_BYTES    = 512;

    // Access size encodings (bytes = 2**size)
    typedef enum logic [1:0] {
        SIZE_BYTE   = 2'd0,
        SIZE_HALF   = 2'd1,
        SIZE_WORD   = 2'd2,
        SIZE_DOUBLE = 2'd3
    } size_e;

    // Controller FSM state encodings
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Power-up image: every byte is zero except the entries listed here
    localparam int       c_INIT_ENTRIES = 3;
    localparam int       c_INIT_ADDR [c_INIT_ENTRIES] = '{16, 32, 48};
    localparam bit [7:0] c_INIT_DATA [c_INIT_ENTRIES] = '{8'd20, 8'd22, 8'd0};

    // Number of bytes moved by an access of the given size
    function automatic logic [3:0] size_bytes(input size_e sz);
        logic [3:0] n;
        case (sz)
            SIZE_BYTE:   n = 4'd1;
            SIZE_HALF:   n = 4'd2;
            SIZE_WORD:   n = 4'd4;
            SIZE_DOUBLE: n = 4'd8;
            default:     n = 4'd1;
        endcase
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/byte_ram_array.sv
`default_nettype none
// ============================================================================
//  Module   : byte_ram_array
//  Purpose  : Byte-wide storage with LANES independent byte ports. Each lane
//             has its own address, byte write enable and synchronous read.
//             Storage has no reset; contents start from the package image.
//  Ports    : clk      - clock, rising edge
//             addr_i   - per-lane byte address
//             we_i     - per-lane byte write enable
//             wdata_i  - per-lane write byte
//             rdata_o  - per-lane read byte (registered, old data on collision)
//  Revision : 1.0  initial release
// ============================================================================
module byte_ram_array
    import data_mem_ctrl_pkg::*;
#(
    parameter int NUM_BYTES = c_DEF_NUM_DATA_BYTES,
    parameter int ADDR_W    = c_DEF_ADDRESS_BUS_WIDTH,
    parameter int LANES     = c_DEF_DATA_BUS_WIDTH / 8
) (
    input  logic                         clk,
    input  logic [LANES-1:0][ADDR_W-1:0] addr_i,
    input  logic [LANES-1:0]             we_i,
    input  logic [LANES-1:0][7:0]        wdata_i,
    output logic [LANES-1:0][7:0]        rdata_o
);

    function automatic logic [NUM_BYTES*8-1:0] f_init_image();
        logic [NUM_BYTES*8-1:0] img;
        img = '0;
        for (int i = 0; i < c_INIT_ENTRIES; i++) begin
            if (c_INIT_ADDR[i] < NUM_BYTES) begin
                img[c_INIT_ADDR[i]*8 +: 8] = c_INIT_DATA[i];
            end
        end
        return img;
    endfunction

    // Flat byte store; the declaration value is the power-up image
    logic [NUM_BYTES*8-1:0] mem_q = f_init_image();
    logic [LANES-1:0][7:0]  rdata_q;

    // Out-of-range lane addresses occur on unused lanes near the top of
    // memory; they never write and read back as zero.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (we_i[k] && (int'(addr_i[k]) < NUM_BYTES)) begin
                mem_q[int'(addr_i[k])*8 +: 8] <= wdata_i[k];
            end
            if (int'(addr_i[k]) < NUM_BYTES) begin
                rdata_q[k] <= mem_q[int'(addr_i[k])*8 +: 8];
            end else begin
                rdata_q[k] <= 8'h00;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_ctrl
//  Purpose  : Request/response byte-addressable data memory controller.
//             One request at a time: IDLE accepts, ACCESS commits writes and
//             loads read data, RESP pulses resp_valid for one cycle.
//             Supports byte/half/word/double accesses, sign/zero extension
//             of narrow reads and error flagging of illegal requests.
//  Ports    : clk, reset_n (async, active-low)
//             cs, req_valid, req_ready     - request handshake
//             memRead, memWrite            - operation (read wins)
//             address, size, sign_ext      - access attributes
//             writeData / readData         - little-endian, LSB-aligned data
//             resp_valid, resp_err         - completion pulse and error flag
//  Revision : 1.0  initial release
// ============================================================================
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int DATA_BUS_WIDTH    = c_DEF_DATA_BUS_WIDTH,
    parameter int ADDRESS_BUS_WIDTH = c_DEF_ADDRESS_BUS_WIDTH,
    parameter int NUM_DATA_BYTES    = c_DEF_NUM_DATA_BYTES
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         cs,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         memRead,
    input  logic                         memWrite,
    input  logic [ADDRESS_BUS_WIDTH-1:0] address,
    input  logic [1:0]                   size,
    input  logic                         sign_ext,
    input  logic [DATA_BUS_WIDTH-1:0]    writeData,
    output logic [DATA_BUS_WIDTH-1:0]    readData,
    output logic                         resp_valid,
    output logic                         resp_err
);

    localparam int c_LANES = DATA_BUS_WIDTH / 8;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_e                        state_q;
    logic                          req_ready_q;
    logic                          resp_valid_q;
    logic                          resp_err_q;
    logic [DATA_BUS_WIDTH-1:0]     read_data_q;
    logic [ADDRESS_BUS_WIDTH-1:0]  addr_q;
    size_e                         size_q;
    logic                          sext_q;
    logic                          is_read_q;
    logic                          err_q;
    logic [DATA_BUS_WIDTH-1:0]     wdata_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                                     w_accept;
    logic [3:0]                               w_req_bytes;
    logic [31:0]                              w_addr_ext;
    logic                                     w_req_err;
    logic [3:0]                               w_cur_bytes;
    logic [ADDRESS_BUS_WIDTH-1:0]             w_base_addr;
    logic [c_LANES-1:0][ADDRESS_BUS_WIDTH-1:0] w_lane_addr;
    logic [c_LANES-1:0]                       w_lane_we;
    logic [c_LANES-1:0][7:0]                  w_lane_wdata;
    logic [c_LANES-1:0][7:0]                  w_lane_rdata;
    logic                                     w_sign_bit;
    logic [7:0]                               w_fill;
    logic [DATA_BUS_WIDTH-1:0]                read_data_d;

    assign w_accept = (state_q == ST_IDLE) && req_ready_q && cs && req_valid
                      && (memRead || memWrite);

    // Legality of the incoming request, evaluated while it is presented
    assign w_req_bytes = size_bytes(size_e'(size));
    assign w_addr_ext  = 32'(address);
    assign w_req_err   = ((w_addr_ext & (32'(w_req_bytes) - 32'd1)) != 32'd0)
                      || ((w_addr_ext + 32'(w_req_bytes)) > 32'(NUM_DATA_BYTES))
                      || ((32'(w_req_bytes) << 3) > 32'(DATA_BUS_WIDTH));

    assign w_cur_bytes = size_bytes(size_q);

    // In IDLE the RAM is addressed from the live request so that read data
    // is already available during ACCESS; afterwards the captured address
    // drives the lanes for the write commit.
    assign w_base_addr = (state_q == ST_IDLE) ? address : addr_q;

    for (genvar k = 0; k < c_LANES; k++) begin : g_lane
        assign w_lane_addr[k]  = w_base_addr + ADDRESS_BUS_WIDTH'(k);
        assign w_lane_we[k]    = (state_q == ST_ACCESS) && !is_read_q && !err_q
                                 && (k < int'(w_cur_bytes));
        assign w_lane_wdata[k] = wdata_q[8*k +: 8];
    end

    byte_ram_array #(
        .NUM_BYTES (NUM_DATA_BYTES),
        .ADDR_W    (ADDRESS_BUS_WIDTH),
        .LANES     (c_LANES)
    ) u_ram (
        .clk     (clk),
        .addr_i  (w_lane_addr),
        .we_i    (w_lane_we),
        .wdata_i (w_lane_wdata),
        .rdata_o (w_lane_rdata)
    );

    // Narrow reads: lanes above the access width get the extension byte,
    // taken from bit 7 of the most significant accessed byte.
    always_comb begin
        w_sign_bit  = 1'b0;
        w_fill      = 8'h00;
        read_data_d = '0;
        for (int k = 0; k < c_LANES; k++) begin
            if (k == int'(w_cur_bytes) - 1) begin
                w_sign_bit = w_lane_rdata[k][7];
            end
        end
        w_fill = (sext_q && w_sign_bit) ? 8'hFF : 8'h00;
        for (int k = 0; k < c_LANES; k++) begin
            read_data_d[8*k +: 8] = (k < int'(w_cur_bytes)) ? w_lane_rdata[k] : w_fill;
        end
    end

    // ------------------------------------------------------------------
    // Controller FSM with registered outputs. Reset aborts any access in
    // flight; because write enables depend on state_q, a write caught in
    // ACCESS by reset is never committed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            read_data_q  <= '0;
            addr_q       <= '0;
            size_q       <= SIZE_BYTE;
            sext_q       <= 1'b0;
            is_read_q    <= 1'b0;
            err_q        <= 1'b0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (w_accept) begin
                        state_q     <= ST_ACCESS;
                        req_ready_q <= 1'b0;
                        addr_q      <= address;
                        size_q      <= size_e'(size);
                        sext_q      <= sign_ext;
                        is_read_q   <= memRead;
                        err_q       <= w_req_err;
                        wdata_q     <= writeData;
                    end
                end
                ST_ACCESS: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    if (is_read_q && !err_q) begin
                        read_data_q <= read_data_d;
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    req_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign readData   = read_data_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_ctrl
//  Purpose  : Self-checking bench for data_mem_ctrl: directed scenarios plus
//             randomized requests compared against a byte-array model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_data_mem_ctrl;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int NB = 512;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cs;
    logic          req_valid;
    logic          req_ready;
    logic          memRead;
    logic          memWrite;
    logic [AW-1:0] address;
    logic [1:0]    size;
    logic          sign_ext;
    logic [DW-1:0] writeData;
    logic [DW-1:0] readData;
    logic          resp_valid;
    logic          resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ref_mem [NB];
    logic [63:0] exp_rd;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DATA_BUS_WIDTH    (DW),
        .ADDRESS_BUS_WIDTH (AW),
        .NUM_DATA_BYTES    (NB)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .memRead    (memRead),
        .memWrite   (memWrite),
        .address    (address),
        .size       (size),
        .sign_ext   (sign_ext),
        .writeData  (writeData),
        .readData   (readData),
        .resp_valid (resp_valid),
        .resp_err   (resp_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_err(input int a, input int sz);
        int nb;
        nb = 1 << sz;
        return ((a % nb) != 0) || ((a + nb) > NB) || ((nb * 8) > DW);
    endfunction

    function automatic logic [63:0] model_read(input int a, input int sz, input bit sx);
        logic [63:0] v;
        int nb;
        nb = 1 << sz;
        v  = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[a+k];
        if (sx && v[8*nb-1]) begin
            for (int k = nb; k < 8; k++) v[8*k +: 8] = 8'hFF;
        end
        return v;
    endfunction

    task automatic idle_inputs();
        cs        = 1'b0;
        req_valid = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        size      = 2'd0;
        sign_ext  = 1'b0;
        writeData = '0;
    endtask

    // Called at a negedge with the controller idle; returns at a negedge
    // with the controller idle again. When junk is set, a different write
    // request is held on the bus while the controller is busy.
    task automatic do_req(input string tag, input bit rd, input bit wr, input int a,
                          input int sz, input bit sx, input logic [63:0] wd, input bit junk);
        bit e;
        int cyc;
        int nb;
        e  = model_err(a, sz);
        nb = 1 << sz;
        cs = 1'b1; req_valid = 1'b1; memRead = rd; memWrite = wr;
        address = AW'(a); size = 2'(sz); sign_ext = sx; writeData = wd;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        if (junk) begin
            memRead = 1'b0; memWrite = 1'b1; address = AW'($urandom);
            size = 2'($urandom); writeData = {$urandom, $urandom};
        end else begin
            req_valid = 1'b0;
        end
        check({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
        while (!resp_valid && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        if (!e) begin
            if (rd) exp_rd = model_read(a, sz, sx);
            else for (int k = 0; k < nb; k++) ref_mem[a+k] = wd[8*k +: 8];
        end
        check({tag, ".latency"}, 64'(cyc), 64'd2);
        check({tag, ".resp_err"}, 64'(resp_err), 64'(e));
        check({tag, ".readData"}, readData, exp_rd);
        @(negedge clk);
        idle_inputs();
        check({tag, ".resp_clear"}, 64'(resp_valid), 64'd0);
        check({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < NB; i++) ref_mem[i] = 8'h00;
        ref_mem[16] = 8'd20;
        ref_mem[32] = 8'd22;
        exp_rd = '0;
        idle_inputs();

        // Reset state
        reset_n = 1'b0;
        #12;
        check("rst.readData", readData, 64'd0);
        check("rst.resp_valid", 64'(resp_valid), 64'd0);
        check("rst.resp_err", 64'(resp_err), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst.req_ready", 64'(req_ready), 64'd1);

        // Initial image read
        do_req("rd16", 1, 0, 16, 3, 0, 64'd0, 0);
        check("rd16.literal", readData, 64'd20);

        // Half-word write then sign/zero-extended reads
        do_req("wr32", 0, 1, 32, 1, 0, 64'hFF80, 0);
        do_req("rd32s", 1, 0, 32, 1, 1, 64'd0, 0);
        check("rd32s.literal", readData, 64'hFFFF_FFFF_FFFF_FF80);
        do_req("rd32z", 1, 0, 32, 1, 0, 64'd0, 0);
        check("rd32z.literal", readData, 64'h0000_0000_0000_FF80);

        // Error cases
        do_req("wr6err", 0, 1, 6, 2, 0, 64'hDEAD_BEEF, 0);
        do_req("rd0", 1, 0, 0, 3, 0, 64'd0, 0);
        do_req("rd8", 1, 0, 8, 3, 1, 64'd0, 0);
        do_req("rd508err", 1, 0, 508, 3, 0, 64'd0, 0);
        do_req("rd600err", 1, 0, 600, 0, 0, 64'd0, 0);
        do_req("wr504", 0, 1, 504, 3, 0, 64'h8877_6655_4433_2211, 0);
        do_req("rd504", 1, 0, 504, 3, 0, 64'd0, 0);
        do_req("wr511err", 0, 1, 511, 1, 0, 64'hABCD, 0);
        do_req("rd510", 1, 0, 510, 1, 1, 64'd0, 0);

        // Back-to-back write then read of the same byte; read wins over write
        do_req("wr100", 0, 1, 100, 0, 0, 64'hA5, 0);
        do_req("rd100", 1, 1, 100, 0, 0, 64'h5A, 0);
        check("rd100.literal", readData, 64'hA5);

        // Reset during ACCESS of a write
        do_req("wr200", 0, 1, 200, 0, 0, 64'h11, 0);
        cs = 1'b1; req_valid = 1'b1; memWrite = 1'b1; address = AW'(200);
        size = 2'd0; writeData = 64'h5A;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        reset_n = 1'b0;
        exp_rd  = '0;
        #1;
        check("rstmid.resp_valid", 64'(resp_valid), 64'd0);
        check("rstmid.readData", readData, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstmid.no_resp", 64'(resp_valid), 64'd0);
            check("rstmid.ready", 64'(req_ready), 64'd1);
        end
        do_req("rd200", 1, 0, 200, 0, 0, 64'd0, 0);

        // Requests with cs low, then with no operation selected
        cs = 1'b0; req_valid = 1'b1; memWrite = 1'b1; address = AW'(300);
        size = 2'd0; writeData = 64'hEE;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cs0.no_resp", 64'(resp_valid), 64'd0);
            check("cs0.ready", 64'(req_ready), 64'd1);
        end
        cs = 1'b1; memWrite = 1'b0; memRead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("noop.no_resp", 64'(resp_valid), 64'd0);
        end
        idle_inputs();
        do_req("rd300", 1, 0, 300, 0, 0, 64'd0, 0);

        // Randomized requests, with junk requests held while busy
        for (int n = 0; n < 150; n++) begin
            bit rd, wr, sx, junk;
            int sz, a;
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            sx   = 1'($urandom_range(0, 1));
            junk = 1'($urandom_range(0, 1));
            sz   = int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 1023));
            else if ($urandom_range(0, 7) == 0) a = int'($urandom_range(0, 63));
            else a = int'($urandom_range(0, 63)) & ~((1 << sz) - 1);
            do_req("rand", rd, wr, a, sz, sx, {$urandom, $urandom}, junk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
